// File: rtl/data_mem_unit.sv
// Byte-addressable data memory with RV32I load/store semantics.
// Stores complete in zero cycles; loads respond 2 cycles after accept while busy blocks new requests.
module data_mem_unit #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  rw_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        err
);
    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_l;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        type_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_val;
    logic              err_q;
    logic [31:0]       mem [DEPTH];

    logic              rd_only, wr_only, st_bad, ld_bad_q, we;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [31:0]       byte_sh, half_sh;
    logic              unused_addr_bits;

    assign addr_l           = addr[ADDR_W-1:0];
    assign unused_addr_bits = ^addr[31:ADDR_W];
    assign rd_only          = mem_rd && !mem_wr;
    assign wr_only          = mem_wr && !mem_rd;

    function automatic logic load_bad(input logic [2:0] t, input logic [1:0] a);
        case (t)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = a[0];
            3'b010:         load_bad = (a != 2'b00);
            default:        load_bad = 1'b1;
        endcase
    endfunction

    function automatic logic store_bad(input logic [2:0] t, input logic [1:0] a);
        case (t)
            3'b000:  store_bad = 1'b0;
            3'b001:  store_bad = a[0];
            3'b010:  store_bad = (a != 2'b00);
            default: store_bad = 1'b1;
        endcase
    endfunction

    // Store lane enables and replicated write data
    always_comb begin
        be = 4'b0000;
        wd = wdata;
        case (rw_type)
            3'b000: begin
                be = 4'b0001 << addr_l[1:0];
                wd = {4{wdata[7:0]}};
            end
            3'b001: begin
                be = addr_l[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
            end
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign st_bad = store_bad(rw_type, addr_l[1:0]);
    assign we     = (state == IDLE) && wr_only && !st_bad && !rst;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_l[ADDR_W-1:2]][i*8 +: 8] <= wd[i*8 +: 8];
            end
        end
    end

    // Load extraction from the word captured during ACCESS
    assign ld_bad_q = load_bad(type_q, addr_q[1:0]);
    always_comb begin
        byte_sh  = word_q >> {addr_q[1:0], 3'b000};
        half_sh  = word_q >> {addr_q[1], 4'b0000};
        load_val = 32'h0;
        case (type_q)
            3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  load_val = {24'h0, byte_sh[7:0]};
            3'b001:  load_val = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  load_val = {16'h0, half_sh[15:0]};
            3'b010:  load_val = word_q;
            default: load_val = 32'h0;
        endcase
        if (ld_bad_q) load_val = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            type_q  <= 3'b000;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= (state == IDLE) && ((mem_rd && mem_wr) || (wr_only && st_bad));
            if (state == IDLE && rd_only) begin
                addr_q <= addr_l;
                type_q <= rw_type;
            end
            if (state == ACCESS) word_q  <= mem[addr_q[ADDR_W-1:2]];
            if (state == RESP)   rdata_q <= load_val;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = (state != IDLE);
        rdata_valid = 1'b0;
        rdata       = rdata_q;
        err         = err_q;
        case (state)
            IDLE:   if (rd_only) state_nxt = ACCESS;
            ACCESS: state_nxt = RESP;
            RESP: begin
                state_nxt   = IDLE;
                rdata_valid = 1'b1;
                rdata       = load_val;
                err         = err_q | ld_bad_q;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit; inputs change and outputs are sampled on falling edges.
module tb_data_mem_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  rw_type = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        rdata_valid, busy, err;

    int tests = 0;
    int fails = 0;

    data_mem_unit #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .rw_type(rw_type),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic store_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                            input logic exp_err, input string name);
        rw_type = t; addr = a; wdata = d; mem_wr = 1'b1;
        @(negedge clk);
        mem_wr = 1'b0;
        tests++;
        if (err !== exp_err) begin
            fails++; $display("FAIL %s err: got %b expected %b", name, err, exp_err);
        end
    endtask

    task automatic load_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] exp_data,
                           input logic exp_err, input string name);
        rw_type = t; addr = a; mem_rd = 1'b1;
        @(negedge clk);
        mem_rd = 1'b0;
        tests++;
        if (busy !== 1'b1 || rdata_valid !== 1'b0) begin
            fails++; $display("FAIL %s access: busy %b valid %b expected 1 0", name, busy, rdata_valid);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || rdata_valid !== 1'b1 || err !== exp_err || rdata !== exp_data) begin
            fails++;
            $display("FAIL %s resp: busy %b valid %b err %b rdata %h expected 1 1 %b %h",
                     name, busy, rdata_valid, err, rdata, exp_err, exp_data);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rdata_valid !== 1'b0 || err !== 1'b0 || rdata !== exp_data) begin
            fails++;
            $display("FAIL %s hold: busy %b valid %b err %b rdata %h expected 0 0 0 %h",
                     name, busy, rdata_valid, err, rdata, exp_data);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rdata_valid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset: busy %b valid %b err %b rdata %h expected 0 0 0 0",
                     busy, rdata_valid, err, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word;
        store_op(3'b010, 32'h10, 32'hDEADBEEF, 1'b0, "sw_10");
        load_op(3'b010, 32'h10, 32'hDEADBEEF, 1'b0, "lw_10");
    endtask

    task automatic test_subword_load;
        load_op(3'b000, 32'h13, 32'hFFFFFFDE, 1'b0, "lb_13");
        load_op(3'b100, 32'h13, 32'h000000DE, 1'b0, "lbu_13");
        load_op(3'b001, 32'h10, 32'hFFFFBEEF, 1'b0, "lh_10");
        load_op(3'b101, 32'h12, 32'h0000DEAD, 1'b0, "lhu_12");
    endtask

    task automatic test_partial_store;
        store_op(3'b000, 32'h11, 32'h12345677, 1'b0, "sb_11");
        load_op(3'b010, 32'h10, 32'hDEAD77EF, 1'b0, "lw_after_sb");
        store_op(3'b001, 32'h12, 32'hAAAA5555, 1'b0, "sh_12");
        load_op(3'b010, 32'h10, 32'h555577EF, 1'b0, "lw_after_sh");
    endtask

    task automatic test_misaligned;
        load_op(3'b010, 32'h12, 32'h0, 1'b1, "lw_misaligned");
        load_op(3'b110, 32'h10, 32'h0, 1'b1, "load_illegal_type");
        store_op(3'b001, 32'h13, 32'h0000FFFF, 1'b1, "sh_misaligned");
        store_op(3'b100, 32'h10, 32'hFFFFFFFF, 1'b1, "store_illegal_type");
        @(negedge clk);
        tests++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL err_single_pulse: got %b expected 0", err);
        end
        load_op(3'b010, 32'h10, 32'h555577EF, 1'b0, "lw_after_bad_stores");
    endtask

    task automatic test_busy_and_conflict;
        rw_type = 3'b010; addr = 32'h10; mem_rd = 1'b1;
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b1; wdata = 32'h0;
        @(negedge clk);
        mem_wr = 1'b0;
        tests++;
        if (rdata_valid !== 1'b1 || err !== 1'b0 || rdata !== 32'h555577EF) begin
            fails++;
            $display("FAIL busy_write_resp: valid %b err %b rdata %h expected 1 0 555577ef",
                     rdata_valid, err, rdata);
        end
        @(negedge clk);
        tests++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL busy_write_err: err %b busy %b expected 0 0", err, busy);
        end
        mem_rd = 1'b1; mem_wr = 1'b1; wdata = 32'h0;
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0;
        tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL conflict: err %b busy %b expected 1 0", err, busy);
        end
        load_op(3'b010, 32'h10, 32'h555577EF, 1'b0, "lw_after_conflict");
    endtask

    task automatic test_back_to_back;
        store_op(3'b010, 32'h20, 32'h11111111, 1'b0, "sw_20");
        store_op(3'b010, 32'h24, 32'h22222222, 1'b0, "sw_24");
        load_op(3'b010, 32'h24, 32'h22222222, 1'b0, "lw_24_after_store");
        load_op(3'b010, 32'h20, 32'h11111111, 1'b0, "lw_20");
        store_op(3'b010, 32'h420, 32'h33333333, 1'b0, "sw_wrap");
        load_op(3'b010, 32'h20, 32'h33333333, 1'b0, "lw_wrap");
    endtask

    task automatic test_reset_abort;
        rw_type = 3'b010; addr = 32'h10; mem_rd = 1'b1;
        @(negedge clk);
        mem_rd = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL abort_in_access: busy %b expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL abort_reset: busy %b valid %b rdata %h expected 0 0 0", busy, rdata_valid, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (rdata_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL abort_no_resp: valid %b busy %b expected 0 0", rdata_valid, busy);
        end
        rst = 1'b1; rw_type = 3'b010; addr = 32'h10; wdata = 32'hFFFFFFFF; mem_wr = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_wr = 1'b0;
        @(negedge clk);
        load_op(3'b010, 32'h10, 32'h555577EF, 1'b0, "lw_retained_after_reset");
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_word;
        test_subword_load;
        test_partial_store;
        test_misaligned;
        test_busy_and_conflict;
        test_back_to_back;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address bits decoded; depth = 2^(ADDR_W-2) 32-bit words.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port mem_rd  input  1  load request, sampled in IDLE only.
REQ-005 SHALL have port mem_wr  input  1  store request, sampled in IDLE only.
REQ-006 SHALL have port rw_type  input  3  access type, RV32I funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 SHALL have port addr  input  32  byte address; only addr[ADDR_W-1:0] used.
REQ-008 SHALL have port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port rdata  output  32  load result, extended to 32 bits.
REQ-010 SHALL have port rdata_valid  output  1  one-cycle pulse marking rdata valid.
REQ-011 SHALL have port busy  output  1  high while a load is in flight; requests ignored.
REQ-012 SHALL have port err  output  1  one-cycle pulse on rejected access.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-014 SHALL accept a request in IDLE when exactly one of mem_rd/mem_wr is high; busy = (state != IDLE).
REQ-015 SHALL, for an accepted legal store, write the selected byte lanes at the rising edge ending the accept cycle and remain in IDLE (zero-latency store, back-to-back stores every cycle).
REQ-016 SHALL derive store byte enables: sb -> lane addr[1:0]; sh -> lanes {addr[1],0} and {addr[1],1}; sw -> all four; wdata replicated onto the enabled lanes.
REQ-017 SHALL, for an accepted legal load, latch addr[ADDR_W-1:0] and rw_type, go IDLE->ACCESS (array read into a word register), ACCESS->RESP, RESP->IDLE.
REQ-018 SHALL assert rdata_valid only in RESP, exactly 2 cycles after the accept edge; rdata holds the result in RESP and keeps it until the next load response.
REQ-019 SHALL extract and extend: lb/lh sign-extend from bit 7/15, lbu/lhu zero-extend, lw unchanged; lane chosen by latched addr[1:0].
REQ-020 SHALL flag misalignment: h/hu with addr[0]=1, w with addr[1:0]!=00; byte accesses never misaligned.
REQ-021 SHALL treat rw_type 011, 110, 111 as illegal for loads; 011, 100, 101, 110, 111 illegal for stores.
REQ-022 SHALL, on a misaligned or illegal store, perform no write, pulse err in the following cycle, stay IDLE.
REQ-023 SHALL, on a misaligned or illegal load, still traverse ACCESS and RESP, present rdata = 0 with rdata_valid=1 and err=1 in RESP.
REQ-024 SHALL, when mem_rd and mem_wr are both high in IDLE, perform neither, pulse err the following cycle, stay IDLE.
REQ-025 SHALL ignore mem_rd/mem_wr entirely while busy (no write, no err, no queueing).
REQ-026 SHALL wrap addresses beyond 2^ADDR_W by discarding upper bits, without error.
REQ-027 SHALL return, for a load accepted the cycle after a store to the same word, the newly written data.

Reset
REQ-028 SHALL on rst: state IDLE, rdata 0, rdata_valid 0, err 0, busy 0, latched address/type 0.
REQ-029 SHALL abort an in-flight load when rst is asserted in ACCESS or RESP; no rdata_valid pulse after the reset edge.
REQ-030 SHALL not clear memory contents on reset and SHALL not write when rst is high in the accept cycle.

Verification
REQ-031 SHALL cover: sw 0xDEADBEEF @0x10, then lw @0x10 -> busy 2 cycles, rdata_valid 2 cycles after accept, rdata 0xDEADBEEF.
REQ-032 SHALL cover: after REQ-031, lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x10 -> 0xFFFFBEEF; lhu @0x12 -> 0x0000DEAD.
REQ-033 SHALL cover: sb 0x12345677 @0x11 over 0xDEADBEEF, then lw @0x10 -> 0xDEAD77EF; sh 0xAAAA5555 @0x12, lw @0x10 -> 0x555577EF.
REQ-034 SHALL cover: lw @0x12 -> err=1, rdata_valid=1, rdata 0 in RESP; sh @0x13 -> err pulse, word @0x10 unchanged.
REQ-035 SHALL cover: mem_wr pulse while busy and mem_rd+mem_wr both high in IDLE -> no write; err only for the simultaneous case.
REQ-036 SHALL cover: rst asserted in ACCESS -> state IDLE next cycle, no rdata_valid, rdata 0, memory word @0x10 retained.
